// File: rtl/key_expander_if.sv
// Key-expander request/read-port bundle: the requester drives start, key and
// round index; the expander returns the selected round key and status.
interface key_expander_if;
  localparam int unsigned KEY_W = 128;
  localparam int unsigned SEL_W = 4;

  logic             start;
  logic [KEY_W-1:0] key_in;
  logic [SEL_W-1:0] round_sel;
  logic [KEY_W-1:0] round_key;
  logic             key_expand_done;
  logic             busy;

  modport master (
    output start, key_in, round_sel,
    input  round_key, key_expand_done, busy
  );

  modport slave (
    input  start, key_in, round_sel,
    output round_key, key_expand_done, busy
  );
endinterface

// File: rtl/key_expander.sv
// AES-128 key schedule: expands one cipher key into 11 stored round keys,
// one round per clock, with a combinational read port over the stored keys.
module key_expander (
  input logic           clock,
  input logic           reset,
  key_expander_if.slave bus
);
  localparam int unsigned KEY_W   = 128;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned RC_W    = 4;
  localparam int unsigned NUM_RK  = 11;
  localparam int unsigned LAST_RC = 10;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t            state, state_next;
  logic              load, step;
  logic [KEY_W-1:0]  rk [NUM_RK];
  logic [RC_W-1:0]   rc;
  logic [7:0]        rcon;
  logic              busy_q, done_q;

  logic [KEY_W-1:0]  prev_rk, next_rk;
  logic [WORD_W-1:0] rot_w, sub_w, temp_w;
  logic [WORD_W-1:0] w0_n, w1_n, w2_n, w3_n;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and datapath strobes; start is only honoured outside EXPAND
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = EXPAND;
        end
      end
      EXPAND: begin
        step = 1'b1;
        if (rc == RC_W'(LAST_RC)) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One key-schedule round from the previous round key
  always_comb prev_rk = rk[rc - RC_W'(1)];
  assign rot_w = {prev_rk[23:0], prev_rk[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign sub_w[8*b +: 8] = SBOX[rot_w[8*b +: 8]];
  end

  assign temp_w  = sub_w ^ {rcon, 24'h0};
  assign w0_n    = prev_rk[127:96] ^ temp_w;
  assign w1_n    = prev_rk[95:64]  ^ w0_n;
  assign w2_n    = prev_rk[63:32]  ^ w1_n;
  assign w3_n    = prev_rk[31:0]   ^ w2_n;
  assign next_rk = {w0_n, w1_n, w2_n, w3_n};

  // Round-key storage: slot 0 loads the cipher key, slot rc takes each new round
  for (genvar i = 0; i < NUM_RK; i++) begin : g_rk
    always_ff @(posedge clock) begin
      if (reset)                            rk[i] <= '0;
      else if (load && i == 0)              rk[i] <= bus.key_in;
      else if (step && rc == RC_W'(i))      rk[i] <= next_rk;
    end
  end

  // Round counter, rcon (GF(2^8) doubling) and registered status
  always_ff @(posedge clock) begin
    if (reset) begin
      rc     <= '0;
      rcon   <= 8'h01;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (load) begin
        rc   <= RC_W'(1);
        rcon <= 8'h01;
      end else if (step) begin
        rc   <= rc + RC_W'(1);
        rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      busy_q <= (state_next == EXPAND);
      done_q <= (state_next == DONE);
    end
  end

  assign bus.round_key       = (bus.round_sel < RC_W'(NUM_RK)) ? rk[bus.round_sel] : '0;
  assign bus.busy            = busy_q;
  assign bus.key_expand_done = done_q;
endmodule

// File: tb/tb_key_expander.sv
// Directed bench for key_expander: FIPS-197 and all-zero key schedules,
// latency/busy timing, ignored restart, reset abort and reset/start priority.
module tb_key_expander;
  logic clock;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  key_expander_if kif ();

  key_expander dut (
    .clock (clock),
    .reset (reset),
    .bus   (kif.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   sel;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] ZERO_KEY = 128'h0;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [127:0] key, input logic [3:0] sel, input logic [127:0] exp);
    vec_t v;
    v.key = key; v.sel = sel; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Pulse start with key, then corrupt key_in; optionally re-pulse start mid-expansion.
  task automatic do_expand(input logic [127:0] key, input int restart_at, input string tag);
    int cycles;
    int busy_cnt;
    kif.key_in = key;
    kif.start  = 1'b1;
    tick();
    kif.start  = 1'b0;
    kif.key_in = ~key;
    check({tag, " done low after start"}, 128'(kif.key_expand_done), 128'h0);
    cycles   = 0;
    busy_cnt = 0;
    while (!kif.key_expand_done && cycles < 20) begin
      if (kif.busy) busy_cnt++;
      kif.start = (cycles == restart_at);
      tick();
      cycles++;
    end
    kif.start = 1'b0;
    check({tag, " latency"}, 128'(cycles), 128'd10);
    check({tag, " busy cycles"}, 128'(busy_cnt), 128'd10);
    check({tag, " busy low in done"}, 128'(kif.busy), 128'h0);
  endtask

  initial begin
    logic [127:0] cur_key;
    logic         have_key;
    logic         saw_done;

    add(FIPS_KEY, 4'd0,  FIPS_KEY);
    add(FIPS_KEY, 4'd1,  128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    add(FIPS_KEY, 4'd2,  128'hf2c295f2_7a96b943_5935807a_7359f67f);
    add(FIPS_KEY, 4'd3,  128'h3d80477d_4716fe3e_1e237e44_6d7a883b);
    add(FIPS_KEY, 4'd4,  128'hef44a541_a8525b7f_b671253b_db0bad00);
    add(FIPS_KEY, 4'd5,  128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc);
    add(FIPS_KEY, 4'd6,  128'h6d88a37a_110b3efd_dbf98641_ca0093fd);
    add(FIPS_KEY, 4'd7,  128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f);
    add(FIPS_KEY, 4'd8,  128'head27321_b58dbad2_312bf560_7f8d292f);
    add(FIPS_KEY, 4'd9,  128'hac7766f3_19fadc21_28d12941_575c006e);
    add(FIPS_KEY, 4'd10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    add(FIPS_KEY, 4'd11, 128'h0);
    add(FIPS_KEY, 4'd12, 128'h0);
    add(FIPS_KEY, 4'd15, 128'h0);
    add(ZERO_KEY, 4'd0,  128'h0);
    add(ZERO_KEY, 4'd1,  128'h62636363_62636363_62636363_62636363);
    add(ZERO_KEY, 4'd2,  128'h9b9898c9_f9fbfbaa_9b9898c9_f9fbfbaa);
    add(ZERO_KEY, 4'd3,  128'h90973450_696ccffa_f2f45733_0b0fac99);
    add(ZERO_KEY, 4'd5,  128'h7f2e2b88_f8443e09_8dda7cbb_f34b9290);
    add(ZERO_KEY, 4'd9,  128'hb1d4d8e2_8a7db9da_1d7bb3de_4c664941);
    add(ZERO_KEY, 4'd10, 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e);
    add(ZERO_KEY, 4'd13, 128'h0);

    reset         = 1'b1;
    kif.start     = 1'b0;
    kif.key_in    = '0;
    kif.round_sel = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("reset done",      128'(kif.key_expand_done), 128'h0);
    check("reset busy",      128'(kif.busy),            128'h0);
    check("reset round_key", kif.round_key,             128'h0);

    // Reset wins over a simultaneous start
    reset      = 1'b1;
    kif.start  = 1'b1;
    kif.key_in = FIPS_KEY;
    tick();
    reset     = 1'b0;
    kif.start = 1'b0;
    check("rst+start busy", 128'(kif.busy), 128'h0);
    saw_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (kif.key_expand_done || kif.busy) saw_done = 1'b1;
    end
    check("rst+start stays idle", 128'(saw_done), 128'h0);
    check("rst+start rk0",        kif.round_key,  128'h0);

    // Table: a key change triggers a fresh expansion (back-to-back from DONE)
    have_key = 1'b0;
    cur_key  = '0;
    for (int i = 0; i < vecs.size(); i++) begin
      if (!have_key || vecs[i].key !== cur_key) begin
        do_expand(vecs[i].key, 4, $sformatf("expand %0d", i));
        cur_key  = vecs[i].key;
        have_key = 1'b1;
      end
      kif.round_sel = vecs[i].sel;
      #1;
      check($sformatf("vec %0d sel %0d", i, vecs[i].sel), kif.round_key, vecs[i].exp);
    end
    check("done held", 128'(kif.key_expand_done), 128'h1);

    // Reset on cycle 4 of EXPAND aborts everything
    kif.key_in = FIPS_KEY;
    kif.start  = 1'b1;
    tick();
    kif.start = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    check("abort busy before reset", 128'(kif.busy), 128'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort busy", 128'(kif.busy),            128'h0);
    check("abort done", 128'(kif.key_expand_done), 128'h0);
    for (int s = 0; s <= 10; s++) begin
      kif.round_sel = 4'(s);
      #1;
      check($sformatf("abort rk %0d", s), kif.round_key, 128'h0);
    end
    saw_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (kif.key_expand_done) saw_done = 1'b1;
    end
    check("abort no done pulse", 128'(saw_done), 128'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/key_expander.md
KEY_EXPANDER -- requirements
Module: key_expander

Interface
REQ-001 Parameters: none; AES-128 only, Nk=4, Nr=10 fixed.
REQ-002 clock  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to begin expansion of key_in.
REQ-005 key_in  input  128  cipher key; key_in[127:96] = w0, key_in[31:0] = w3, byte 0 = key_in[127:120].
REQ-006 round_sel  input  4  round-key index for read port, 0..10.
REQ-007 round_key  output  128  round key selected by round_sel, same word/byte packing as key_in.
REQ-008 key_expand_done  output  1  level, high while all 11 round keys are valid; drives the state manager's key_expand_done input.
REQ-009 busy  output  1  high while expansion is in progress.

Function
REQ-010 FSM states: IDLE, EXPAND, DONE. Reset state is IDLE.
REQ-011 Storage: 11 x 128-bit round-key registers rk[0..10], a 4-bit round counter rc, and an 8-bit rcon register.
REQ-012 IDLE or DONE, start=1 at edge E0: rk[0] <= key_in, rc <= 1, rcon <= 0x01, key_expand_done <= 0, state <= EXPAND.
REQ-013 EXPAND, each edge: rk[rc] <= next(rk[rc-1], rcon), rc <= rc+1, rcon <= xtime(rcon); xtime(0x80) = 0x1B.
REQ-014 next(): temp = SubWord(RotWord(w3)) XOR {rcon,24'h0}; w0' = w0^temp; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
REQ-015 RotWord({a,b,c,d}) = {b,c,d,a}; SubWord applies the FIPS-197 AES S-box to each byte. The S-box is an internal combinational lookup; exactly 4 instances are used.
REQ-016 rcon sequence for rounds 1..10 SHALL be 01,02,04,08,10,20,40,80,1B,36.
REQ-017 Edge on which rc=10 is written (E10): state <= DONE, key_expand_done <= 1. Latency from the start sample edge to key_expand_done high is exactly 10 cycles.
REQ-018 busy = 1 exactly when state = EXPAND.
REQ-019 DONE: key_expand_done stays high and rk[] is held until reset or a new start.
REQ-020 start=1 while in EXPAND is ignored; the expansion in progress continues unaffected.
REQ-021 start in DONE restarts the expansion per REQ-012. key_expand_done falls on that same edge.
REQ-022 round_key = rk[round_sel] combinationally. round_sel 11..15 returns 128'h0.
REQ-023 round_key SHALL reflect register contents at all times, including during EXPAND. Consumers use it only when key_expand_done=1.
REQ-024 key_in is sampled only on the start edge; later changes do not affect the expansion.

Reset
REQ-025 reset=1 at an edge: state <= IDLE, rc <= 0, rcon <= 0x01, all rk[] <= 0, key_expand_done <= 0, busy <= 0.
REQ-026 Reset takes priority over start on the same edge.
REQ-027 Reset asserted during EXPAND aborts the expansion. No partial key_expand_done pulse is produced.
REQ-028 After reset, with round_sel=0, round_key = 128'h0.

Verification
REQ-029 FIPS-197 key 2b7e1516_28aed2a6_abf71588_09cf4f3c, pulse start:
  - key_expand_done rises exactly 10 cycles after the start edge;
  - round_sel=1 gives a0fafe17_88542cb1_23a33939_2a6c7605;
  - round_sel=10 gives d014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  - round_sel=0 gives the original key.
REQ-030 All-zero key, start:
  - round_sel=1 gives 62636363_62636363_62636363_62636363;
  - round_sel=10 gives b4ef5bcb_3e92e211_23e951cf_6f8f188e.
REQ-031 Busy/ignore/invalid-index check:
  - busy is high for exactly 10 cycles;
  - a second start pulse on cycle 5 of EXPAND does not alter the REQ-029 results or timing;
  - round_sel=12 gives 0.
REQ-032 Reset mid-expansion: reset asserted on cycle 4 of EXPAND gives the next cycle IDLE, busy=0, key_expand_done=0, round_key=0 for round_sel=0..10.
REQ-033 Back-to-back keys: after DONE with the REQ-029 key, start with the all-zero key:
  - key_expand_done drops on that edge;
  - key_expand_done rises 10 cycles later;
  - results match REQ-030.
REQ-034 start and reset both asserted on the same edge: the block remains in IDLE and key_expand_done stays 0.
